// File: rtl/hqc_rsdecod_pkg.sv
// Purpose: shared types and parameter helpers for the HQC RS decoder sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, correction-capacity / code-length selectors, watchdog width helper.
package hqc_rsdecod_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYND,
    ST_ELP,
    ST_ROOT,
    ST_EV,
    ST_CORR,
    ST_FIN
  } state_t;

  // RS correction capacity per security level.
  function automatic int delta_sel(input int sec);
    int r;
    case (sec)
      192:     r = 16;
      256:     r = 29;
      default: r = 15;
    endcase
    return r;
  endfunction

  // RS code length (symbols) per security level.
  function automatic int n1_sel(input int sec);
    int r;
    case (sec)
      192:     r = 56;
      256:     r = 90;
      default: r = 46;
    endcase
    return r;
  endfunction

  // Counter width able to hold the value 'timeout'; never narrower than 1 bit.
  function automatic int wd_width(input int timeout);
    int r;
    if (timeout < 1) r = 1;
    else             r = $clog2(timeout + 1);
    return r;
  endfunction

endpackage

// File: rtl/hqc_rsdecod_watchdog.sv
// Purpose: per-stage cycle counter flagging when a stage has run LIMIT cycles.
// Latency: expired is combinational from the count register.
// Backpressure: none; saturates at LIMIT until cleared.
// Ports: clk, rst (sync, active-high), clr, en, load/load_val, expired.
module hqc_rsdecod_watchdog #(
  parameter int W     = 10,
  parameter int LIMIT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  assign expired = (cnt == LIM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hqc_rsdecod_seq.sv
// Purpose: sequences syndrome/ELP/root/error-value/correction stages for one codeword per start.
// Latency: sum of stage latencies + 6 cycles; done pulses the cycle after the last valid or expiry.
// Backpressure: start_i accepted only in IDLE, otherwise dropped; no queueing.
// Ports: clk_i/rst_i; start_i -> busy_o/done_o/fail_o/timeout_o/err_cnt_o;
//        *_start_o launch pulses, *_valid_i completions, synd_zero_i/deg_sigma_i/root_cnt_i stage results.
module hqc_rsdecod_seq
  import hqc_rsdecod_pkg::*;
#(
  parameter int PARAM_SECURITY = 128,
  parameter int PARAM_DELTA    = delta_sel(PARAM_SECURITY),
  parameter bit CONST_TIME     = 1'b1,
  parameter int TIMEOUT        = 1023
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic       timeout_o,
  output logic [7:0] err_cnt_o,
  output logic       synd_start_o,
  output logic       elp_start_o,
  output logic       root_start_o,
  output logic       ev_start_o,
  output logic       corr_start_o,
  input  logic       synd_valid_i,
  input  logic       elp_valid_i,
  input  logic       root_valid_i,
  input  logic       ev_valid_i,
  input  logic       corr_valid_i,
  input  logic       synd_zero_i,
  input  logic [7:0] deg_sigma_i,
  input  logic [7:0] root_cnt_i
);

  localparam int         WD_W    = wd_width(TIMEOUT);
  localparam logic [7:0] DELTA_B = 8'(PARAM_DELTA);

  state_t     state;
  logic       zero_r;
  logic [7:0] deg_r;
  logic       fail_r;

  logic       in_stage;
  logic       stage_vld;
  logic       to_fin;
  logic       zero_nxt;
  logic [7:0] deg_nxt;
  logic       fail_nxt;
  logic       expired;

  assign in_stage = (state != ST_IDLE) && (state != ST_FIN);

  // Only the current stage's valid matters; everything computed here is
  // committed solely on that valid, so stray values elsewhere are harmless.
  always_comb begin
    stage_vld = 1'b0;
    to_fin    = 1'b0;
    zero_nxt  = zero_r;
    deg_nxt   = deg_r;
    fail_nxt  = fail_r;
    case (state)
      ST_SYND: begin
        stage_vld = synd_valid_i;
        zero_nxt  = synd_zero_i;
        to_fin    = !CONST_TIME && synd_zero_i;
      end
      ST_ELP: begin
        stage_vld = elp_valid_i;
        deg_nxt   = deg_sigma_i;
        // Too many errors to correct, or an empty locator despite nonzero syndromes.
        fail_nxt  = fail_r || (deg_sigma_i > DELTA_B) ||
                    ((deg_sigma_i == 8'd0) && !zero_r);
      end
      ST_ROOT: begin
        stage_vld = root_valid_i;
        fail_nxt  = fail_r || (root_cnt_i != deg_r);
        to_fin    = !CONST_TIME && fail_nxt;
      end
      ST_EV: begin
        stage_vld = ev_valid_i;
      end
      ST_CORR: begin
        stage_vld = corr_valid_i;
        to_fin    = 1'b1;
      end
      default: ;
    endcase
  end

  // Cleared whenever the state is about to change (or is not a stage),
  // so the count is zero in every stage entry cycle.
  hqc_rsdecod_watchdog #(
    .W     (WD_W),
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (!in_stage || stage_vld || expired),
    .en       (in_stage),
    .load     (1'b0),
    .load_val ({WD_W{1'b0}}),
    .expired  (expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      zero_r       <= 1'b0;
      deg_r        <= '0;
      fail_r       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      fail_o       <= 1'b0;
      timeout_o    <= 1'b0;
      err_cnt_o    <= '0;
      synd_start_o <= 1'b0;
      elp_start_o  <= 1'b0;
      root_start_o <= 1'b0;
      ev_start_o   <= 1'b0;
      corr_start_o <= 1'b0;
    end else begin
      synd_start_o <= 1'b0;
      elp_start_o  <= 1'b0;
      root_start_o <= 1'b0;
      ev_start_o   <= 1'b0;
      corr_start_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state        <= ST_SYND;
            synd_start_o <= 1'b1;
            busy_o       <= 1'b1;
            fail_o       <= 1'b0;
            timeout_o    <= 1'b0;
            err_cnt_o    <= '0;
            zero_r       <= 1'b0;
            deg_r        <= '0;
            fail_r       <= 1'b0;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          // A valid in the expiry cycle takes priority over the watchdog.
          if (stage_vld) begin
            zero_r <= zero_nxt;
            deg_r  <= deg_nxt;
            fail_r <= fail_nxt;
            if (to_fin) begin
              state     <= ST_FIN;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              fail_o    <= fail_nxt;
              err_cnt_o <= (fail_nxt || zero_nxt) ? 8'd0 : deg_nxt;
            end else begin
              case (state)
                ST_SYND: begin state <= ST_ELP;  elp_start_o  <= 1'b1; end
                ST_ELP:  begin state <= ST_ROOT; root_start_o <= 1'b1; end
                ST_ROOT: begin state <= ST_EV;   ev_start_o   <= 1'b1; end
                ST_EV:   begin state <= ST_CORR; corr_start_o <= 1'b1; end
                default: ;
              endcase
            end
          end else if (expired) begin
            state     <= ST_FIN;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
            fail_o    <= 1'b1;
            err_cnt_o <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hqc_rsdecod_seq.sv
// Purpose: directed self-checking bench for hqc_rsdecod_seq (constant-time and early-exit builds).
// Latency: cycle numbers count from the accept cycle (0); checks sample on the falling edge.
// Backpressure: stage valids are returned a programmed number of cycles after each launch.
module tb_hqc_rsdecod_seq;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [4:0] vld;          // 0 synd, 1 elp, 2 root, 3 ev, 4 corr
  logic       zero;
  logic [7:0] deg, rcnt;

  logic       busy_a, done_a, fail_a, to_a;
  logic [7:0] err_a;
  logic [4:0] ss_a;
  logic       busy_b, done_b, fail_b, to_b;
  logic [7:0] err_b;
  logic [4:0] ss_b;

  logic       sel;
  logic       busy_m, done_m, fail_m, to_m;
  logic [7:0] err_m;
  logic [4:0] ss_m;

  int total, bad;
  int lat [5];
  bit hold_start, stray_corr, rst_in_root;
  int n_start [5];
  int c_start [5];
  int c_done;
  logic busy1, busy_d, fail_c, to_c;
  logic [7:0] err_c;

  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign fail_m = sel ? fail_b : fail_a;
  assign to_m   = sel ? to_b   : to_a;
  assign err_m  = sel ? err_b  : err_a;
  assign ss_m   = sel ? ss_b   : ss_a;

  hqc_rsdecod_seq #(.PARAM_SECURITY(128), .CONST_TIME(1'b1), .TIMEOUT(15)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a),
    .busy_o(busy_a), .done_o(done_a), .fail_o(fail_a), .timeout_o(to_a), .err_cnt_o(err_a),
    .synd_start_o(ss_a[0]), .elp_start_o(ss_a[1]), .root_start_o(ss_a[2]),
    .ev_start_o(ss_a[3]), .corr_start_o(ss_a[4]),
    .synd_valid_i(vld[0]), .elp_valid_i(vld[1]), .root_valid_i(vld[2]),
    .ev_valid_i(vld[3]), .corr_valid_i(vld[4]),
    .synd_zero_i(zero), .deg_sigma_i(deg), .root_cnt_i(rcnt)
  );

  hqc_rsdecod_seq #(.PARAM_SECURITY(128), .CONST_TIME(1'b0), .TIMEOUT(15)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b),
    .busy_o(busy_b), .done_o(done_b), .fail_o(fail_b), .timeout_o(to_b), .err_cnt_o(err_b),
    .synd_start_o(ss_b[0]), .elp_start_o(ss_b[1]), .root_start_o(ss_b[2]),
    .ev_start_o(ss_b[3]), .corr_start_o(ss_b[4]),
    .synd_valid_i(vld[0]), .elp_valid_i(vld[1]), .root_valid_i(vld[2]),
    .ev_valid_i(vld[3]), .corr_valid_i(vld[4]),
    .synd_zero_i(zero), .deg_sigma_i(deg), .root_cnt_i(rcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cw(input logic z, input logic [7:0] d, input logic [7:0] r);
    zero = z;
    deg  = d;
    rcnt = r;
    for (int i = 0; i < 5; i++) lat[i] = 4;
    hold_start  = 1'b0;
    stray_corr  = 1'b0;
    rst_in_root = 1'b0;
  endtask

  // Decode one codeword on DUT s, answering each launch after lat[] cycles (-1 = never).
  task automatic run(input bit s);
    int due [5];
    int cyc;
    int stray_due;
    bit fin;
    for (int i = 0; i < 5; i++) begin
      n_start[i] = 0;
      c_start[i] = -1;
      due[i]     = -1;
    end
    c_done = -1; stray_due = -1; fin = 1'b0; cyc = 0;
    busy1 = 1'b0; busy_d = 1'b1; fail_c = 1'b0; to_c = 1'b0; err_c = '0;
    sel = s;
    @(negedge clk);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    while (!fin && cyc < 120) begin
      @(negedge clk);
      cyc++;
      vld = '0;
      if (cyc == 1) busy1 = busy_m;
      if (!hold_start || done_m) begin
        start_a = 1'b0;
        start_b = 1'b0;
      end
      for (int i = 0; i < 5; i++) begin
        if (ss_m[i]) begin
          n_start[i]++;
          c_start[i] = cyc;
          if (lat[i] >= 0) due[i] = cyc + lat[i];
        end
      end
      for (int i = 0; i < 5; i++) if (due[i] == cyc) vld[i] = 1'b1;
      if (stray_corr && ss_m[1]) stray_due = cyc + 1;
      if (cyc == stray_due) vld[4] = 1'b1;
      if (done_m) begin
        c_done = cyc; fail_c = fail_m; to_c = to_m; err_c = err_m; busy_d = busy_m;
        fin = 1'b1; vld = '0;
      end
      if (rst_in_root && ss_m[2]) begin
        rst = 1'b1; fin = 1'b1; vld = '0;
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic check_run(input string t, input logic [4:0] m, input int d,
                           input logic f, input logic to, input logic [7:0] e);
    logic [4:0] got;
    int tot;
    got = '0; tot = 0;
    for (int i = 0; i < 5; i++) begin
      got[i] = (n_start[i] != 0);
      tot += n_start[i];
    end
    chk({t, "_launch_mask"}, 32'(got), 32'(m));
    chk({t, "_launch_pulses"}, tot, $countones(m));
    chk({t, "_done_cycle"}, c_done, d);
    chk({t, "_busy_at_done"}, 32'(busy_d), 0);
    chk({t, "_fail"}, 32'(fail_c), 32'(f));
    chk({t, "_timeout"}, 32'(to_c), 32'(to));
    chk({t, "_err_cnt"}, 32'(err_c), 32'(e));
  endtask

  initial begin
    int n;
    total = 0; bad = 0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; vld = '0; sel = 1'b0;
    set_cw(1'b0, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    chk("reset_busy_a", 32'(busy_a), 0);
    chk("reset_done_a", 32'(done_a), 0);
    chk("reset_starts_a", 32'(ss_a), 0);
    chk("reset_err_a", 32'(err_a), 0);
    chk("reset_fail_b", 32'(fail_b), 0);
    chk("reset_timeout_b", 32'(to_b), 0);
    rst = 1'b0;

    // Zero syndrome, constant time: every stage still runs.
    set_cw(1'b1, 8'd0, 8'd0); run(1'b0);
    chk("t1_busy_cycle1", 32'(busy1), 1);
    chk("t1_synd_start_cycle", c_start[0], 1);
    check_run("t1", 5'b11111, 26, 1'b0, 1'b0, 8'd0);

    // Zero syndrome, early exit: only the syndrome stage.
    set_cw(1'b1, 8'd0, 8'd0); run(1'b1);
    check_run("t2", 5'b00001, 6, 1'b0, 1'b0, 8'd0);

    set_cw(1'b0, 8'd5, 8'd5); run(1'b0);
    check_run("t3", 5'b11111, 26, 1'b0, 1'b0, 8'd5);

    set_cw(1'b0, 8'd5, 8'd4); run(1'b0);
    check_run("t4", 5'b11111, 26, 1'b1, 1'b0, 8'd0);

    set_cw(1'b0, 8'd5, 8'd5); run(1'b1);
    check_run("t5", 5'b11111, 26, 1'b0, 1'b0, 8'd5);

    // Root mismatch with early exit skips EV and CORR.
    set_cw(1'b0, 8'd5, 8'd4); run(1'b1);
    check_run("t6", 5'b00111, 16, 1'b1, 1'b0, 8'd0);

    set_cw(1'b0, 8'd16, 8'd16); run(1'b0);
    check_run("t7_delta_plus1", 5'b11111, 26, 1'b1, 1'b0, 8'd0);

    set_cw(1'b0, 8'd15, 8'd15); run(1'b0);
    check_run("t8_delta", 5'b11111, 26, 1'b0, 1'b0, 8'd15);

    set_cw(1'b0, 8'd0, 8'd0); run(1'b0);
    check_run("t9_deg0_nonzero", 5'b11111, 26, 1'b1, 1'b0, 8'd0);

    // ELP never answers: watchdog fires 15 cycles into the stage.
    set_cw(1'b0, 8'd5, 8'd5); lat[1] = -1; run(1'b0);
    chk("t10_done_after_elp", c_done - c_start[1], 16);
    check_run("t10", 5'b00011, 22, 1'b1, 1'b1, 8'd0);

    // ELP answers exactly in the expiry cycle: valid wins.
    set_cw(1'b0, 8'd5, 8'd5); lat[1] = 15; run(1'b0);
    chk("t11_root_after_elp", c_start[2] - c_start[1], 16);
    check_run("t11", 5'b11111, 37, 1'b0, 1'b0, 8'd5);

    // Zero-latency stages: valid in the launch cycle.
    set_cw(1'b0, 8'd3, 8'd3);
    for (int i = 0; i < 5; i++) lat[i] = 0;
    run(1'b0);
    check_run("t12_zero_lat", 5'b11111, 6, 1'b0, 1'b0, 8'd3);

    // start held while busy and a stray corr valid during ELP are both ignored.
    set_cw(1'b0, 8'd2, 8'd2); hold_start = 1'b1; stray_corr = 1'b1; run(1'b0);
    check_run("t13_hold_stray", 5'b11111, 26, 1'b0, 1'b0, 8'd2);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n += int'(busy_a) + int'(ss_a != 5'd0);
    end
    chk("t13_no_requeue", n, 0);

    // Reset in ROOT: back to IDLE, no done, quiet outputs.
    set_cw(1'b0, 8'd5, 8'd5); rst_in_root = 1'b1; run(1'b0);
    chk("t14_no_done_before_rst", c_done, -1);
    @(negedge clk);
    rst = 1'b0;
    chk("t14_busy", 32'(busy_a), 0);
    chk("t14_fail", 32'(fail_a), 0);
    chk("t14_timeout", 32'(to_a), 0);
    chk("t14_err", 32'(err_a), 0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n += int'(done_a) + int'(busy_a) + int'(ss_a != 5'd0);
    end
    chk("t14_quiet_after_rst", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
